etapa_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the synchronous instruction memory.
- Owns the program counter and drives the memory address with it.
- Selects the next PC: sequential, branch or jump.
- Latches the returned instruction plus PC+4 into the IF/ID pipeline register.
- Supports hazard stall, flush, debug single-step and halt detection.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_id_latch.sv | 45 ++++
 rtl/etapa_fetch.sv | 101 ++++++++++
 tb/tb_etapa_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline stages.
package mips_pkg;

  localparam int unsigned NBITS = 32;

  localparam logic [NBITS-1:0] RESET_PC  = 32'd4;
  localparam logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [NBITS-1:0] NOP_WORD  = 32'h0000_0000;

  // Next-PC source chosen by the fetch stage each cycle.
  typedef enum logic [2:0] {
    PcHold,
    PcSeq,
    PcBranch,
    PcJump,
    PcHalt
  } pc_sel_e;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: loads a fetched instruction with its PC+4, or is flushed to a bubble.
module if_id_latch #(
  parameter int unsigned      NBITS    = mips_pkg::NBITS,
  parameter logic [NBITS-1:0] NOP_WORD = NBITS'(mips_pkg::NOP_WORD)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic [NBITS-1:0] i_instruction,
  input  logic [NBITS-1:0] i_pc4,
  output logic [NBITS-1:0] o_instruction,
  output logic [NBITS-1:0] o_pc4
);

  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] pc4_q, pc4_d;

  // Flush wins over load; with neither asserted the register holds.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (i_flush) begin
      instr_d = NOP_WORD;
      pc4_d   = '0;
    end else if (i_load) begin
      instr_d = i_instruction;
      pc4_d   = i_pc4;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc4         = pc4_q;

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: owns the PC, picks the next PC and feeds the IF/ID register.
module etapa_fetch #(
  parameter int unsigned      NBITS     = mips_pkg::NBITS,
  parameter logic [NBITS-1:0] RESET_PC  = NBITS'(mips_pkg::RESET_PC),
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(mips_pkg::HALT_WORD),
  parameter logic [NBITS-1:0] NOP_WORD  = NBITS'(mips_pkg::NOP_WORD)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_instruction,
  input  logic             i_stall,
  input  logic             i_jump,
  input  logic [NBITS-1:0] i_jump_addr,
  input  logic             i_branch_taken,
  input  logic [NBITS-1:0] i_branch_target,
  input  logic             i_debug_mode,
  input  logic             i_step,
  output logic [NBITS-1:0] o_PC,
  output logic [NBITS-1:0] o_ifid_instruction,
  output logic [NBITS-1:0] o_ifid_pc4,
  output logic             o_halt
);

  import mips_pkg::*;

  logic [NBITS-1:0] pc_q, pc_d;
  logic [NBITS-1:0] pc_plus4;
  logic             halt_q, halt_d;
  logic             advance;
  logic             ifid_load, ifid_flush;
  pc_sel_e          sel;

  assign advance  = !halt_q && (!i_debug_mode || i_step);
  assign pc_plus4 = pc_q + NBITS'(4);

  always_comb begin
    sel = PcHold;
    if (advance) begin
      if (i_branch_taken)                  sel = PcBranch;
      else if (i_jump)                     sel = PcJump;
      else if (i_stall)                    sel = PcHold;
      else if (i_instruction == HALT_WORD) sel = PcHalt;
      else                                 sel = PcSeq;
    end
  end

  // Redirect targets are word-aligned by dropping the two low bits.
  always_comb begin
    pc_d       = pc_q;
    halt_d     = halt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    unique case (sel)
      PcBranch: begin
        pc_d       = {i_branch_target[NBITS-1:2], 2'b00};
        ifid_flush = 1'b1;
      end
      PcJump: begin
        pc_d       = {i_jump_addr[NBITS-1:2], 2'b00};
        ifid_flush = 1'b1;
      end
      PcHalt: begin
        halt_d     = 1'b1;
        ifid_flush = 1'b1;
      end
      PcSeq: begin
        pc_d      = pc_plus4;
        ifid_load = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc_q   <= RESET_PC;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
    end
  end

  if_id_latch #(
    .NBITS   (NBITS),
    .NOP_WORD(NOP_WORD)
  ) u_if_id_latch (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (ifid_load),
    .i_flush      (ifid_flush),
    .i_instruction(i_instruction),
    .i_pc4        (pc_plus4),
    .o_instruction(o_ifid_instruction),
    .o_pc4        (o_ifid_pc4)
  );

  assign o_PC   = pc_q;
  assign o_halt = halt_q;

endmodule

// File: tb/tb_etapa_fetch.sv
// Self-checking bench for etapa_fetch: directed scenarios plus randomized traffic vs a reference model.
module tb_etapa_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        stall, jump, br, dbg, step;
  logic [31:0] jaddr, btgt;
  logic [31:0] o_pc, o_ii, o_p4;
  logic        o_halt;

  // Reference model state.
  logic [31:0] m_pc, m_ii, m_p4;
  logic        m_h;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  etapa_fetch dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_instruction     (instr),
    .i_stall           (stall),
    .i_jump            (jump),
    .i_jump_addr       (jaddr),
    .i_branch_taken    (br),
    .i_branch_target   (btgt),
    .i_debug_mode      (dbg),
    .i_step            (step),
    .o_PC              (o_pc),
    .o_ifid_instruction(o_ii),
    .o_ifid_pc4        (o_p4),
    .o_halt            (o_halt)
  );

  // Apply one rising edge to both the model and the DUT, then settle.
  task automatic tick();
    if (!rst) begin
      m_pc = 32'd4; m_ii = 32'd0; m_p4 = 32'd0; m_h = 1'b0;
    end else if (!m_h && (!dbg || step)) begin
      if (br) begin
        m_pc = btgt & ~32'd3; m_ii = 32'd0; m_p4 = 32'd0;
      end else if (jump) begin
        m_pc = jaddr & ~32'd3; m_ii = 32'd0; m_p4 = 32'd0;
      end else if (stall) begin
        // hold everything
      end else if (instr == 32'hFFFF_FFFF) begin
        m_ii = 32'd0; m_p4 = 32'd0; m_h = 1'b1;
      end else begin
        m_ii = instr;
        m_p4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; instr = 32'h0001_1020; stall = 1'b0; jump = 1'b0; br = 1'b0;
    dbg = 1'b0; step = 1'b0; jaddr = 32'd0; btgt = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0; stall = 1'b1;
    tick();
    rst = 1'b1; stall = 1'b0;
    checks++;
    if ({o_pc, o_ii, o_p4, o_halt} !== {32'd4, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got pc=%h ins=%h pc4=%h halt=%b want pc=00000004 ins=0 pc4=0 halt=0",
               o_pc, o_ii, o_p4, o_halt);
    end
  endtask

  task automatic test_free_run();
    instr = 32'h0001_1020;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({o_pc, o_ii, o_p4} !== {32'd8 + 32'(4 * i), 32'h0001_1020, 32'd8 + 32'(4 * i)}) begin
        errors++;
        $display("FAIL free_run[%0d]: got pc=%h ins=%h pc4=%h want pc=%h ins=00011020 pc4=%h",
                 i, o_pc, o_ii, o_p4, 32'd8 + 32'(4 * i), 32'd8 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({o_pc, o_ii, o_p4} !== {32'd12, 32'h0001_1020, 32'd12}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got pc=%h ins=%h pc4=%h want pc=0000000c ins=00011020 pc4=0000000c",
                 i, o_pc, o_ii, o_p4);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (o_pc !== 32'd16) begin
      errors++;
      $display("FAIL stall_release: got pc=%h want pc=00000010", o_pc);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    checks++;
    if (o_pc !== 32'd20) begin
      errors++;
      $display("FAIL simul_setup: got pc=%h want pc=00000014", o_pc);
    end
    stall = 1'b1; jump = 1'b1; jaddr = 32'h40; br = 1'b1; btgt = 32'h3D;
    tick();
    stall = 1'b0; jump = 1'b0; br = 1'b0;
    checks++;
    if ({o_pc, o_ii} !== {32'h3C, 32'd0}) begin
      errors++;
      $display("FAIL simul_branch_wins: got pc=%h ins=%h want pc=0000003c ins=00000000", o_pc, o_ii);
    end
  endtask

  task automatic test_halt();
    jump = 1'b1; jaddr = 32'h24;
    tick();
    jump = 1'b0;
    instr = 32'hFFFF_FFFF;
    tick();
    checks++;
    if ({o_pc, o_ii, o_halt} !== {32'd36, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL halt_enter: got pc=%h ins=%h halt=%b want pc=00000024 ins=0 halt=1",
               o_pc, o_ii, o_halt);
    end
    instr = 32'h0001_1020; br = 1'b1; btgt = 32'h100; dbg = 1'b1; step = 1'b1;
    tick();
    checks++;
    if ({o_pc, o_halt} !== {32'd36, 1'b1}) begin
      errors++;
      $display("FAIL halt_sticky: got pc=%h halt=%b want pc=00000024 halt=1", o_pc, o_halt);
    end
    rst = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if ({o_pc, o_ii, o_p4, o_halt} !== {32'd4, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL halt_reset: got pc=%h ins=%h pc4=%h halt=%b want pc=00000004 ins=0 pc4=0 halt=0",
               o_pc, o_ii, o_p4, o_halt);
    end
  endtask

  task automatic test_debug();
    dbg = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (o_pc !== 32'd4) begin
      errors++;
      $display("FAIL debug_idle: got pc=%h want pc=00000004", o_pc);
    end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      checks++;
      if (o_pc !== 32'd8 + 32'(4 * i)) begin
        errors++;
        $display("FAIL debug_step[%0d]: got pc=%h want pc=%h", i, o_pc, 32'd8 + 32'(4 * i));
      end
    end
    dbg = 1'b0;
  endtask

  task automatic test_wrap();
    jump = 1'b1; jaddr = 32'hFFFF_FFFF;
    tick();
    jump = 1'b0;
    checks++;
    if (o_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_setup: got pc=%h want pc=fffffffc", o_pc);
    end
    instr = 32'h1234_5678;
    tick();
    checks++;
    if ({o_pc, o_ii, o_p4} !== {32'd0, 32'h1234_5678, 32'd0}) begin
      errors++;
      $display("FAIL wrap: got pc=%h ins=%h pc4=%h want pc=00000000 ins=12345678 pc4=00000000",
               o_pc, o_ii, o_p4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 63) != 0);
      br    = ($urandom_range(0, 7) == 0);
      jump  = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      btgt  = $urandom;
      jaddr = $urandom;
      if (i % 100 == 0) dbg = ($urandom_range(0, 1) == 1);
      step  = ($urandom_range(0, 1) == 1);
      instr = ($urandom_range(0, 39) == 0) ? 32'hFFFF_FFFF : $urandom;
      tick();
      checks++;
      if ({o_pc, o_ii, o_p4, o_halt} !== {m_pc, m_ii, m_p4, m_h}) begin
        errors++;
        $display("FAIL random[%0d]: got pc=%h ins=%h pc4=%h halt=%b want pc=%h ins=%h pc4=%h halt=%b",
                 i, o_pc, o_ii, o_p4, o_halt, m_pc, m_ii, m_p4, m_h);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_free_run();
    test_stall();
    test_simultaneous();
    test_halt();
    test_debug();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
